matrix_nxn_multiply: RTL
========================

MATRIX_NXN_MULTIPLY -- requirements
Module: matrix_nxn_multiply

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 16, unsigned element width in bits, legal range 4..32.
REQ-003 SHALL have parameter SATURATE, default 0, result width rule (0 = wrap modulo 2^W, 1 = clamp to 2^W-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port source_ready  input  1  downstream ready to take the result.
REQ-007 SHALL have port input_valid  input  1  A, B and accumulate are valid this cycle.
REQ-008 SHALL have port accumulate  input  1  when sampled at acceptance, 1 selects M <= M + A*B and 0 selects M <= A*B.
REQ-009 SHALL have port A  input  N*N*W  operand; element [i][j] at bits (i*N+j)*W +: W.
REQ-010 SHALL have port B  input  N*N*W  operand; same packing as A.
REQ-011 SHALL have port M  output  N*N*W  result, registered; same packing as A.
REQ-012 SHALL have port sink_ready  output  1  block can accept an operand pair.
REQ-013 SHALL have port output_valid  output  1  M holds a completed result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, COMPUTE, DONE.
REQ-015 SHALL drive sink_ready = 1 in IDLE only and output_valid = 1 in DONE only; both decoded from registered state.
REQ-016 SHALL accept an operand pair on a rising edge where state = IDLE and input_valid = 1.
REQ-016 SHALL, on that edge, latch A, B and accumulate internally, clear counters i and k, and enter COMPUTE.
REQ-017 SHALL preload the N*N accumulators on acceptance with 0 when accumulate = 0, or with current M zero-extended when accumulate = 1.
REQ-018 SHALL, in COMPUTE, use N parallel MACs; each cycle acc[i][j] += Alat[i][k]*Blat[k][j] for all j.
REQ-019 SHALL order the COMPUTE iteration with k incrementing fastest (0..N-1), then i (0..N-1); exactly N*N COMPUTE cycles.
REQ-020 SHALL size each accumulator at 2W+clog2(N)+1 bits so that no internal overflow occurs.
REQ-021 SHALL, on the final COMPUTE edge (i = k = N-1), write every accumulator to M using the REQ-003 rule and enter DONE.
REQ-022 SHALL give a latency from the acceptance edge to the first cycle with output_valid = 1 of exactly N*N+1 rising edges.
REQ-023 SHALL stay in DONE with M stable until a rising edge with source_ready = 1, then enter IDLE.
REQ-024 SHALL ignore input_valid in COMPUTE and DONE; a pair held across the DONE->IDLE edge is accepted on the next edge, not the same one.
REQ-025 SHALL treat A and B changes after acceptance as having no effect on the current result.
REQ-026 SHALL hold M unchanged from the IDLE entry edge until the next REQ-021 write.
REQ-027 SHALL interpret all arithmetic as unsigned.

Reset
REQ-028 SHALL, on rst = 1 asynchronously, force state IDLE, M = 0, output_valid = 0 and sink_ready = 1, and clear counters and accumulators.
REQ-029 SHALL, on reset asserted during COMPUTE or DONE, abort the operation; the aborted result is never presented.
REQ-030 SHALL accept input_valid on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover: N=4, W=16, accumulate=0, A={{0,1,2,3},{4,5,6,7},{8,9,0,1},{2,3,4,5}}, B={{1,2,1,2},{2,4,2,4},{1,2,1,2},{2,4,2,4}} -> output_valid rises 17 edges after acceptance, M={{10,20,10,20},{34,68,34,68},{28,56,28,56},{22,44,22,44}}.
REQ-032 SHALL cover: repeat REQ-031 with accumulate=1 -> M={{20,40,20,40},{68,136,68,136},{56,112,56,112},{44,88,44,88}}.
REQ-033 SHALL cover: N=4, W=8, all elements 255 -> SATURATE=0 gives every M element 4; SATURATE=1 gives every M element 255.
REQ-034 SHALL cover: source_ready held 0 for 10 cycles in DONE -> output_valid and M stable, sink_ready = 0; input_valid pulses ignored; release -> IDLE next edge.
REQ-035 SHALL cover: rst pulsed at COMPUTE cycle 7 -> M = 0, output_valid = 0, sink_ready = 1 immediately; new pair then completes with correct result.
REQ-036 SHALL cover: N=2, W=16, A={{1,2},{3,4}}, B={{5,6},{7,8}} -> latency 5 edges, M={{19,22},{43,50}}.

Source files
------------

// File: rtl/matrix_nxn_multiply.sv
// N x N unsigned matrix multiply with optional accumulate: M <= A*B or M <= M + A*B.
// One row of N MACs per cycle; k advances fastest, then i, for N*N compute cycles.
module matrix_nxn_multiply #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             source_ready,
  input  logic             input_valid,
  input  logic             accumulate,
  input  logic [N*N*W-1:0] A,
  input  logic [N*N*W-1:0] B,
  output logic [N*N*W-1:0] M,
  output logic             sink_ready,
  output logic             output_valid
);
  localparam int CW = $clog2(N);
  localparam int AW = 2*W + $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt_i, cnt_k;
  logic [W-1:0]  a_lat   [N][N];
  logic [W-1:0]  b_lat   [N][N];
  logic [AW-1:0] acc     [N][N];
  logic [AW-1:0] acc_nxt [N][N];
  logic          accept, last_step;

  assign accept    = (state == IDLE) && input_valid;
  assign last_step = (state == COMPUTE) && (cnt_i == CW'(N-1)) && (cnt_k == CW'(N-1));

  assign sink_ready   = (state == IDLE);
  assign output_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (input_valid)  state_nxt = COMPUTE;
      COMPUTE: if (last_step)    state_nxt = DONE;
      DONE:    if (source_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only row cnt_i moves this cycle; every column j of that row gets one MAC.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_nxt[i][j] = acc[i][j];
        if (CW'(i) == cnt_i)
          acc_nxt[i][j] = acc[i][j] + AW'(a_lat[i][cnt_k]) * AW'(b_lat[cnt_k][j]);
      end
    end
  end

  function automatic logic [W-1:0] clamp(input logic [AW-1:0] v);
    if (SATURATE != 0 && (|v[AW-1:W])) return {W{1'b1}};
    return v[W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_i <= '0;
      cnt_k <= '0;
      M     <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_lat[i][j] <= '0;
          b_lat[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (accept) begin
      cnt_i <= '0;
      cnt_k <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_lat[i][j] <= A[(i*N+j)*W +: W];
          b_lat[i][j] <= B[(i*N+j)*W +: W];
          acc[i][j]   <= accumulate ? AW'(M[(i*N+j)*W +: W]) : '0;
        end
      end
    end else if (state == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc_nxt[i][j];
        end
      end
      if (cnt_k == CW'(N-1)) begin
        cnt_k <= '0;
        cnt_i <= cnt_i + 1'b1;
      end else begin
        cnt_k <= cnt_k + 1'b1;
      end
      // Final step writes the result including this cycle's MACs.
      if (last_step) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            M[(i*N+j)*W +: W] <= clamp(acc_nxt[i][j]);
          end
        end
      end
    end
  end

endmodule
